// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit restoring divide sequencer (DIV/DIVU -> HI/LO).
// Define DIV_SIGNED_EN to enable signed DIV (magnitude divide + sign fix-up).
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

    // Truncating division: quotient sign is the XOR, remainder follows the dividend.
    assign quo_fix = neg_quo_q ? (~dq_q + WIDTH'(1)) : dq_q;
    assign rem_fix = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == S_IDLE && start) begin
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign dvd_mag          = dividend;
    assign dvs_mag          = divisor;
    assign quo_fix          = dq_q;
    assign rem_fix          = rem_q;
`endif

    // One trial subtraction per step on the shared adder: r + ~d + 1.
    logic [WIDTH-1:0] step_r;
    logic [WIDTH:0]   step_sum;
    logic             step_co;

    assign step_r   = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
    assign step_sum = {1'b0, step_r} + {1'b0, ~dvs_q} + (WIDTH+1)'(1);
    assign step_co  = step_sum[WIDTH];

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    dvs_d  = dvs_mag;
                    dq_d   = dvd_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = step_co ? step_sum[WIDTH-1:0] : step_r;
                dq_d  = {dq_q[WIDTH-2:0], step_co};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d   = quo_fix;
                rmd_d   = rem_fix;
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: arithmetic/timing model compared every cycle,
// plus directed vectors with hand-computed literals.
module tb_div_ctrl;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(32), .STEPS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .is_signed(is_signed),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division on magnitudes; divide-by-zero gives all-ones / dividend.
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                      output logic [31:0] q, output logic [31:0] r);
        logic        sa, sb;
        logic [31:0] ma, mb, uq, ur;
        if (b == 0) begin
            q = '1;
            r = a;
            return;
        end
        sa = SGN & s & a[31];
        sb = SGN & s & b[31];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        uq = ma / mb;
        ur = ma % mb;
        q  = (sa ^ sb) ? -uq : uq;
        r  = sa ? -ur : ur;
    endfunction

    // Transaction-level model: accept when idle, done 33 edges after accept (0 for /0).
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_q = '0; m_r = '0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
            end
        end else if (start) begin
            model_div(dividend, divisor, is_signed, p_q, p_r);
            m_busy = 1'b1;
            if (divisor == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b1;
            end else begin
                m_cnt = 33;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_quotient", quotient, m_q);
            check("cyc_remainder", remainder, m_r);
            check("cyc_div_zero", 32'(div_zero), 32'(m_dz));
        end
    end

    // Pulse start for one edge, then wait (bounded) for done; lat = edges until done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'hFFFFFFFF, 32'h00000001, 1'b0},
        '{32'h00000000, 32'h00000005, 1'b0},
        '{32'h12345678, 32'h80000001, 1'b0},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
        '{32'h00000003, 32'hFFFFFFFF, 1'b1},
        '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1}
    };

    initial begin
        int lat;
        int ndone;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // DIVU 100/7
        do_op(32'd100, 32'd7, 1'b0, lat);
        check("t1_latency", 32'(lat), 32'd34);
        check("t1_q", quotient, 32'd14);
        check("t1_r", remainder, 32'd2);
        check("t1_dz", 32'(div_zero), 32'd0);

        // Back-to-back divide by zero
        @(posedge clk);
        #1;
        do_op(32'd5, 32'd0, 1'b0, lat);
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_q", quotient, 32'hFFFFFFFF);
        check("t2_r", remainder, 32'd5);
        check("t2_dz", 32'(div_zero), 32'd1);

        // Start during the done cycle is ignored
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_cycle_start_busy", 32'(busy), 32'd0);
        check("done_cycle_start_q", quotient, 32'hFFFFFFFF);

        // Start pulse while busy is ignored
        @(posedge clk);
        #1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        dividend = 32'd77;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t3_single_done", 32'(ndone), 32'd1);
        check("t3_q", quotient, 32'd100);
        check("t3_r", remainder, 32'd0);

        // Signed cases
        @(posedge clk);
        #1;
        do_op(-32'sd7, 32'd2, 1'b1, lat);
`ifdef DIV_SIGNED_EN
        check("t4a_q", quotient, 32'hFFFFFFFD);
        check("t4a_r", remainder, 32'hFFFFFFFF);
`endif
        @(posedge clk);
        #1;
        do_op(32'd7, -32'sd2, 1'b1, lat);
        check("t4b_latency", 32'(lat), 32'd34);
`ifdef DIV_SIGNED_EN
        check("t4b_q", quotient, 32'hFFFFFFFD);
        check("t4b_r", remainder, 32'd1);
`endif

        // Most-negative / -1
        @(posedge clk);
        #1;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
`ifdef DIV_SIGNED_EN
        check("t5_div_q", quotient, 32'h80000000);
        check("t5_div_r", remainder, 32'd0);
`else
        check("t5_div_q", quotient, 32'd0);
        check("t5_div_r", remainder, 32'h80000000);
`endif
        @(posedge clk);
        #1;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
        check("t5_divu_q", quotient, 32'd0);
        check("t5_divu_r", remainder, 32'h80000000);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            check("vec_latency", 32'(lat), 32'd34);
        end

        // Reset mid-operation
        @(posedge clk);
        #1;
        do_op(32'd1000, 32'd7, 1'b0, lat);
        check("pre_rst_q", quotient, 32'd142);
        check("pre_rst_r", remainder, 32'd6);
        @(posedge clk);
        #1;
        dividend = 32'd50000;
        divisor  = 32'd123;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_q", quotient, 32'd0);
        check("t6_rst_r", remainder, 32'd0);
        check("t6_rst_dz", 32'(div_zero), 32'd0);
        #14 rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6_no_done", 32'(ndone), 32'd0);
        @(posedge clk);
        #1;
        do_op(32'd50000, 32'd123, 1'b0, lat);
        check("t6_latency", 32'(lat), 32'd34);
        check("t6_q", quotient, 32'd406);
        check("t6_r", remainder, 32'd62);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
